// File: rtl/img_pkg.sv
// Shared image-pipeline types: pixel encoding and the packed
// output byte carried through the byte FIFO.
package img_pkg;

   localparam int PIX_W = 8;
   localparam logic [PIX_W-1:0] PIX_ON = 8'd255;
   localparam logic [PIX_W-1:0] PIX_OFF = 8'd0;

   typedef struct packed {
      logic [7:0] data;
      logic       eol;
      logic       eof;
   } byte_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full
// FIFO succeeds only when a read happens in the same cycle.
module sync_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr, rd;

   // Handshake qualification and pointer/count next state
   always_comb begin
      empty_o   = (cnt_q == '0);
      full_o    = (cnt_q == (AW+1)'(DEPTH));
      rd        = rd_en_i && !empty_o;
      wr        = wr_en_i && (!full_o || rd);
      rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
      wr_ptr_d  = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d     = cnt_q;
      unique case ({wr, rd})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array, written only on accepted writes
   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/bin_pack.sv
// Packs a binarized pixel stream MSB-first into bytes, one
// partial byte at each row end, queued through a small FIFO.
module bin_pack import img_pkg::*; #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bin_valid,
   input  logic [7:0] bin_in,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic [7:0] byte_data,
   output logic       byte_eol,
   output logic       byte_eof,
   output logic       overflow
);

   localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    acc_q, acc_d, acc_set;
   logic          ovf_q, ovf_d;
   logic          pix, last_col, last_row, done;
   logic          full, empty, pop;
   byte_t         wr_byte, rd_byte;

   // Pixel placement, byte completion and counter next state
   always_comb begin
      pix      = bin_in[PIX_W-1];
      last_col = (col_q == CW'(IMAGE_WIDTH - 1));
      last_row = (row_q == RW'(IMAGE_HEIGHT - 1));
      acc_set  = acc_q | ({7'b0, pix} << (3'd7 - bit_q));
      done     = bin_valid && ((bit_q == 3'd7) || last_col);
      pop      = !empty && byte_ready;
      wr_byte  = '{data: acc_set, eol: last_col,
                   eof: last_col && last_row};
      col_d    = col_q;
      row_d    = row_q;
      bit_d    = bit_q;
      acc_d    = acc_q;
      if (bin_valid) begin
         if (done) begin
            acc_d = '0;
            bit_d = '0;
         end else begin
            acc_d = acc_set;
            bit_d = bit_q + 3'd1;
         end
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
      ovf_d = ovf_q | (done && full && !pop);
   end

   // Counter, accumulator and sticky overflow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
         bit_q <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         bit_q <= bit_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   sync_byte_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH($bits(byte_t))
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (done),
      .wr_data_i(wr_byte),
      .rd_en_i  (byte_ready),
      .rd_data_o(rd_byte),
      .full_o   (full),
      .empty_o  (empty)
   );

   // Output view of the FIFO head
   always_comb begin
      byte_valid = !empty;
      byte_data  = rd_byte.data;
      byte_eol   = rd_byte.eol;
      byte_eof   = rd_byte.eof;
      overflow   = ovf_q;
   end

endmodule

// File: tb/tb_bin_pack.sv
// Bench for bin_pack: four geometries share one clock, each with
// its own expected-byte queue checked on every output transfer.
module tb_bin_pack;
   import img_pkg::*;

   typedef struct {
      logic [15:0] pix;
      logic [7:0]  b0;
      logic [7:0]  b1;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst [4];
   logic       v   [4];
   logic [7:0] din [4];
   logic       rdy [4];
   logic       bv  [4];
   logic [7:0] bd  [4];
   logic       eol [4];
   logic       eof [4];
   logic       ovf [4];

   int   Wv [4] = '{16, 12, 320, 1};
   int   Hv [4] = '{2, 2, 240, 3};
   bit   use_model [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   byte_t      q [4][$];
   int         rcv [4];
   int         mcol [4];
   int         mrow [4];
   int         mbit [4];
   logic [7:0] macc [4];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = (g == 0) ? 16 : (g == 1) ? 12 :
                         (g == 2) ? 320 : 1;
      localparam int H = (g == 0) ? 2 : (g == 1) ? 2 :
                         (g == 2) ? 240 : 3;
      bin_pack #(
         .IMAGE_WIDTH (W),
         .IMAGE_HEIGHT(H),
         .FIFO_DEPTH  (4)
      ) dut (
         .clk       (clk),
         .rst       (rst[g]),
         .bin_valid (v[g]),
         .bin_in    (din[g]),
         .byte_valid(bv[g]),
         .byte_ready(rdy[g]),
         .byte_data (bd[g]),
         .byte_eol  (eol[g]),
         .byte_eof  (eof[g]),
         .overflow  (ovf[g])
      );
   end

   task automatic chk(bit ok, string name, int act, int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      byte_t e;
      for (int i = 0; i < 4; i++) begin
         if (!rst[i] && bv[i] && rdy[i]) begin
            if (q[i].size() == 0) begin
               chk(1'b0, $sformatf("unexpected_byte_u%0d", i),
                   int'({bd[i], eol[i], eof[i]}), 0);
            end else begin
               e = q[i].pop_front();
               chk({bd[i], eol[i], eof[i]} == e,
                   $sformatf("byte_u%0d_n%0d", i, rcv[i]),
                   int'({bd[i], eol[i], eof[i]}), int'(e));
            end
            rcv[i]++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic model(int i, bit p);
      byte_t e;
      bit lc;
      macc[i][7 - mbit[i]] = p;
      lc = (mcol[i] == Wv[i] - 1);
      if (mbit[i] == 7 || lc) begin
         e.data = macc[i];
         e.eol  = lc;
         e.eof  = lc && (mrow[i] == Hv[i] - 1);
         q[i].push_back(e);
         macc[i] = '0;
         mbit[i] = 0;
      end else begin
         mbit[i]++;
      end
      if (lc) begin
         mcol[i] = 0;
         mrow[i] = (mrow[i] == Hv[i] - 1) ? 0 : mrow[i] + 1;
      end else begin
         mcol[i]++;
      end
   endtask

   task automatic pix(int i, bit p);
      v[i]   = 1'b1;
      din[i] = p ? PIX_ON : PIX_OFF;
      if (use_model[i]) model(i, p);
      tick();
      v[i]   = 1'b0;
      din[i] = 8'h00;
   endtask

   task automatic push(int i, logic [7:0] d, bit l, bit f);
      byte_t e;
      e.data = d;
      e.eol  = l;
      e.eof  = f;
      q[i].push_back(e);
   endtask

   // Reset one unit, with pixels offered during reset to be ignored.
   task automatic rst_inst(int i);
      rst[i] = 1'b1;
      v[i]   = 1'b1;
      din[i] = PIX_ON;
      tick();
      tick();
      rst[i] = 1'b0;
      v[i]   = 1'b0;
      din[i] = 8'h00;
      q[i].delete();
      mcol[i] = 0;
      mrow[i] = 0;
      mbit[i] = 0;
      macc[i] = '0;
   endtask

   task automatic drain(int i, int budget);
      int n = 0;
      rdy[i] = 1'b1;
      while (q[i].size() > 0 && n < budget) begin
         tick();
         n++;
      end
      chk(q[i].size() == 0, $sformatf("drain_u%0d", i),
          q[i].size(), 0);
   endtask

   initial begin
      vec_t vt [6];
      int   r0;
      bit   p;
      vt[0] = '{16'hAAAA, 8'hAA, 8'hAA};
      vt[1] = '{16'hAAAA, 8'hAA, 8'hAA};
      vt[2] = '{16'hFF00, 8'hFF, 8'h00};
      vt[3] = '{16'h0F3C, 8'h0F, 8'h3C};
      vt[4] = '{16'h0001, 8'h00, 8'h01};
      vt[5] = '{16'h8000, 8'h80, 8'h00};

      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b1;
         v[i] = 1'b0;
         din[i] = 8'h00;
         rdy[i] = 1'b0;
         rcv[i] = 0;
         mcol[i] = 0;
         mrow[i] = 0;
         mbit[i] = 0;
         macc[i] = '0;
      end
      tick();
      tick();
      chk(bv[0] == 1'b0, "rst_valid", int'(bv[0]), 0);
      chk(bd[0] == 8'h00, "rst_data", int'(bd[0]), 0);
      chk(eol[0] == 1'b0, "rst_eol", int'(eol[0]), 0);
      chk(eof[0] == 1'b0, "rst_eof", int'(eof[0]), 0);
      chk(ovf[0] == 1'b0, "rst_ovf", int'(ovf[0]), 0);
      for (int i = 0; i < 4; i++) rst[i] = 1'b0;

      // Row vectors on the 16x2 unit, ready held high
      rdy[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push(0, vt[k].b0, 1'b0, 1'b0);
         push(0, vt[k].b1, 1'b1, k[0]);
         for (int b = 15; b >= 0; b--) pix(0, vt[k].pix[b]);
      end
      drain(0, 20);
      chk(ovf[0] == 1'b0, "table_ovf", int'(ovf[0]), 0);

      // Overflow: six bytes into a four-deep FIFO while stalled
      rst_inst(0);
      rdy[0] = 1'b0;
      push(0, 8'hFF, 1'b0, 1'b0);
      push(0, 8'hFF, 1'b1, 1'b0);
      push(0, 8'hFF, 1'b0, 1'b0);
      push(0, 8'hFF, 1'b1, 1'b1);
      for (int n = 0; n < 48; n++) pix(0, 1'b1);
      tick();
      chk(ovf[0] == 1'b1, "ovf_set", int'(ovf[0]), 1);
      for (int n = 0; n < 3; n++) begin
         chk(bv[0] == 1'b1, "stall_valid", int'(bv[0]), 1);
         chk({bd[0], eol[0], eof[0]} == {8'hFF, 2'b00},
             "stall_head", int'({bd[0], eol[0], eof[0]}),
             int'({8'hFF, 2'b00}));
         tick();
      end
      r0 = rcv[0];
      drain(0, 20);
      tick();
      tick();
      chk(bv[0] == 1'b0, "ovf_empty", int'(bv[0]), 0);
      chk(rcv[0] - r0 == 4, "ovf_count", rcv[0] - r0, 4);
      chk(ovf[0] == 1'b1, "ovf_sticky", int'(ovf[0]), 1);

      // Full FIFO, pop coincides with completing pixel
      rst_inst(0);
      chk(ovf[0] == 1'b0, "ovf_cleared", int'(ovf[0]), 0);
      rdy[0] = 1'b0;
      push(0, 8'hFF, 1'b0, 1'b0);
      push(0, 8'hFF, 1'b1, 1'b0);
      push(0, 8'hFF, 1'b0, 1'b0);
      push(0, 8'hFF, 1'b1, 1'b1);
      push(0, 8'hFF, 1'b0, 1'b0);
      for (int n = 0; n < 39; n++) pix(0, 1'b1);
      rdy[0] = 1'b1;
      pix(0, 1'b1);
      drain(0, 20);
      chk(ovf[0] == 1'b0, "simul_pop_ovf", int'(ovf[0]), 0);

      // 12-wide row: full byte then partial byte
      rdy[1] = 1'b1;
      push(1, 8'hFF, 1'b0, 1'b0);
      push(1, 8'hF0, 1'b1, 1'b0);
      for (int n = 0; n < 12; n++) pix(1, 1'b1);
      drain(1, 20);

      // Width 1: every pixel closes a row
      rdy[3] = 1'b1;
      for (int n = 0; n < 6; n++) pix(3, (n % 3) != 1);
      drain(3, 20);
      chk(rcv[3] == 6, "w1_count", rcv[3], 6);

      // Mid-row reset discards the partial byte
      rdy[2] = 1'b1;
      for (int n = 0; n < 5; n++) pix(2, 1'b1);
      rst_inst(2);
      tick();
      chk(bv[2] == 1'b0, "midrst_empty", int'(bv[2]), 0);
      r0 = rcv[2];
      for (int n = 0; n < 8; n++) pix(2, 1'b1);
      drain(2, 20);
      tick();
      chk(rcv[2] - r0 == 1, "midrst_count", rcv[2] - r0, 1);

      // Full random frame with random backpressure
      rst_inst(2);
      rcv[2] = 0;
      for (int n = 0; n < 320 * 240; n++) begin
         rdy[2] = ($urandom_range(0, 3) != 0);
         p = 1'($urandom);
         pix(2, p);
      end
      drain(2, 100);
      tick();
      chk(rcv[2] == 9600, "frame_count", rcv[2], 9600);
      chk(ovf[2] == 1'b0, "frame_ovf", int'(ovf[2]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
